// File: rtl/axi4lite_periph_bridge.sv
// AXI4-Lite single-beat responder driving a req/ack peripheral bus.
// Alternating write/read arbitration, ack timeout to SLVERR, held responses.
module axi4lite_periph_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_awvalid_i,
  input  logic [31:0] inport_awaddr_i,
  input  logic        inport_wvalid_i,
  input  logic [31:0] inport_wdata_i,
  input  logic [3:0]  inport_wstrb_i,
  input  logic        inport_bready_i,
  input  logic        inport_arvalid_i,
  input  logic [31:0] inport_araddr_i,
  input  logic        inport_rready_i,
  output logic        inport_awready_o,
  output logic        inport_wready_o,
  output logic        inport_bvalid_o,
  output logic [1:0]  inport_bresp_o,
  output logic        inport_arready_o,
  output logic        inport_rvalid_o,
  output logic [31:0] inport_rdata_o,
  output logic [1:0]  inport_rresp_o,
  output logic [31:0] outport_addr_o,
  output logic [31:0] outport_data_wr_o,
  output logic [3:0]  outport_wr_o,
  output logic        outport_rd_o,
  input  logic        outport_ack_i,
  input  logic        outport_error_i,
  input  logic [31:0] outport_data_rd_i
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic       TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_BRESP,
    ST_RRESP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                prio_wr_q, prio_wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic wr_elig_c, rd_elig_c, wr_grant_c, rd_grant_c, timeout_c;
  logic unused_c;

  // Word alignment discards the low address bits.
  assign unused_c = ^{inport_awaddr_i[1:0], inport_araddr_i[1:0]};

  // Arbitration: write wins a conflict only when it holds priority.
  assign wr_elig_c  = inport_awvalid_i & inport_wvalid_i;
  assign rd_elig_c  = inport_arvalid_i;
  assign wr_grant_c = (state_q == ST_IDLE) & wr_elig_c & (prio_wr_q | ~rd_elig_c);
  assign rd_grant_c = (state_q == ST_IDLE) & rd_elig_c & ~wr_grant_c;
  assign timeout_c  = TIMEOUT_EN & (cnt_q == TIMEOUT_LAST);

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      prio_wr_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      prio_wr_q <= prio_wr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    prio_wr_d = prio_wr_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_grant_c) begin
          addr_d    = {inport_awaddr_i[ADDR_W-1:2], 2'b00};
          wdata_d   = inport_wdata_i;
          strb_d    = inport_wstrb_i;
          prio_wr_d = 1'b0;
          cnt_d     = '0;
          // An all-zero strobe completes without touching the peripheral.
          if (inport_wstrb_i != '0) begin
            state_d = ST_WRITE;
          end else begin
            bresp_d = RESP_OKAY;
            state_d = ST_BRESP;
          end
        end else if (rd_grant_c) begin
          addr_d    = {inport_araddr_i[ADDR_W-1:2], 2'b00};
          prio_wr_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_READ;
        end
      end
      ST_WRITE: begin
        if (outport_ack_i) begin
          bresp_d = outport_error_i ? RESP_SLVERR : RESP_OKAY;
          state_d = ST_BRESP;
        end else if (timeout_c) begin
          bresp_d = RESP_SLVERR;
          state_d = ST_BRESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READ: begin
        if (outport_ack_i) begin
          rresp_d = outport_error_i ? RESP_SLVERR : RESP_OKAY;
          rdata_d = outport_data_rd_i;
          state_d = ST_RRESP;
        end else if (timeout_c) begin
          rresp_d = RESP_SLVERR;
          rdata_d = '0;
          state_d = ST_RRESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BRESP: begin
        if (inport_bready_i) state_d = ST_IDLE;
      end
      ST_RRESP: begin
        if (inport_rready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign inport_awready_o  = wr_grant_c;
  assign inport_wready_o   = wr_grant_c;
  assign inport_arready_o  = rd_grant_c;
  assign inport_bvalid_o   = (state_q == ST_BRESP);
  assign inport_rvalid_o   = (state_q == ST_RRESP);
  assign inport_bresp_o    = bresp_q;
  assign inport_rresp_o    = rresp_q;
  assign inport_rdata_o    = rdata_q;
  assign outport_addr_o    = addr_q;
  assign outport_data_wr_o = wdata_q;
  assign outport_wr_o      = (state_q == ST_WRITE) ? strb_q : '0;
  assign outport_rd_o      = (state_q == ST_READ);

endmodule

// File: tb/tb_axi4lite_periph_bridge.sv
// Self-checking bench for axi4lite_periph_bridge: directed cases plus randomized
// transactions scored against a latency/response model.
module tb_axi4lite_periph_bridge;

  localparam int TO = 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        inport_awvalid_i = 1'b0;
  logic [31:0] inport_awaddr_i  = '0;
  logic        inport_wvalid_i  = 1'b0;
  logic [31:0] inport_wdata_i   = '0;
  logic [3:0]  inport_wstrb_i   = '0;
  logic        inport_bready_i  = 1'b0;
  logic        inport_arvalid_i = 1'b0;
  logic [31:0] inport_araddr_i  = '0;
  logic        inport_rready_i  = 1'b0;
  logic        outport_ack_i    = 1'b0;
  logic        outport_error_i  = 1'b0;
  logic [31:0] outport_data_rd_i = '0;
  logic        inport_awready_o, inport_wready_o, inport_bvalid_o;
  logic [1:0]  inport_bresp_o;
  logic        inport_arready_o, inport_rvalid_o;
  logic [31:0] inport_rdata_o;
  logic [1:0]  inport_rresp_o;
  logic [31:0] outport_addr_o, outport_data_wr_o;
  logic [3:0]  outport_wr_o;
  logic        outport_rd_o;

  int n_checks = 0;
  int n_pass   = 0;

  axi4lite_periph_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inport_awvalid_i(inport_awvalid_i), .inport_awaddr_i(inport_awaddr_i),
    .inport_wvalid_i(inport_wvalid_i), .inport_wdata_i(inport_wdata_i),
    .inport_wstrb_i(inport_wstrb_i), .inport_bready_i(inport_bready_i),
    .inport_arvalid_i(inport_arvalid_i), .inport_araddr_i(inport_araddr_i),
    .inport_rready_i(inport_rready_i),
    .inport_awready_o(inport_awready_o), .inport_wready_o(inport_wready_o),
    .inport_bvalid_o(inport_bvalid_o), .inport_bresp_o(inport_bresp_o),
    .inport_arready_o(inport_arready_o), .inport_rvalid_o(inport_rvalid_o),
    .inport_rdata_o(inport_rdata_o), .inport_rresp_o(inport_rresp_o),
    .outport_addr_o(outport_addr_o), .outport_data_wr_o(outport_data_wr_o),
    .outport_wr_o(outport_wr_o), .outport_rd_o(outport_rd_o),
    .outport_ack_i(outport_ack_i), .outport_error_i(outport_error_i),
    .outport_data_rd_i(outport_data_rd_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One complete transaction, entered and left at posedge+1.
  // ack_dly: ack in cycle C+ack_dly (0 = never); rdy_dly: idle cycles before ready.
  task automatic txn(input bit is_wr, input logic [31:0] a_addr, input logic [31:0] a_data,
                     input logic [3:0] a_strb, input int ack_dly, input bit a_err,
                     input logic [31:0] a_prd, input int rdy_dly);
    logic [31:0] eaddr, erdata;
    logic [1:0]  eresp;
    bit          access, acked;
    int          lat;
    eaddr  = {a_addr[31:2], 2'b00};
    access = !(is_wr && a_strb == 4'h0);
    acked  = access && ack_dly >= 1 && ack_dly <= TO;
    lat    = !access ? 1 : (acked ? ack_dly + 1 : TO + 1);
    eresp  = !access ? OKAY : (acked ? (a_err ? SLVERR : OKAY) : SLVERR);
    erdata = acked ? a_prd : 32'h0;

    if (is_wr) begin
      inport_awvalid_i = 1'b1; inport_wvalid_i = 1'b1;
      inport_awaddr_i = a_addr; inport_wdata_i = a_data; inport_wstrb_i = a_strb;
    end else begin
      inport_arvalid_i = 1'b1; inport_araddr_i = a_addr;
    end
    #1;
    chk("ready", 32'({inport_awready_o, inport_wready_o, inport_arready_o}),
        is_wr ? 32'h6 : 32'h1);
    step();
    inport_awvalid_i = 1'b0; inport_wvalid_i = 1'b0; inport_arvalid_i = 1'b0;
    inport_awaddr_i = $urandom; inport_araddr_i = $urandom;
    inport_wdata_i = $urandom; inport_wstrb_i = 4'($urandom);

    for (int k = 1; k <= lat; k++) begin
      outport_ack_i     = (k == ack_dly);
      outport_error_i   = (k == ack_dly) ? a_err : 1'($urandom);
      outport_data_rd_i = (k == ack_dly) ? a_prd : $urandom;
      if (k < lat) begin
        chk("req", 32'({outport_wr_o, outport_rd_o}),
            is_wr ? 32'({a_strb, 1'b0}) : 32'h1);
        chk("addr", outport_addr_o, eaddr);
        if (is_wr) chk("wdata", outport_data_wr_o, a_data);
      end else begin
        chk("req_drop", 32'({outport_wr_o, outport_rd_o}), 32'h0);
      end
      chk(is_wr ? "bvalid_lat" : "rvalid_lat",
          32'(is_wr ? inport_bvalid_o : inport_rvalid_o), 32'(k == lat));
      if (k < lat) step();
    end

    for (int j = 0; j <= rdy_dly; j++) begin
      if (is_wr) inport_bready_i = (j == rdy_dly);
      else       inport_rready_i = (j == rdy_dly);
      chk(is_wr ? "bvalid_hold" : "rvalid_hold",
          32'(is_wr ? inport_bvalid_o : inport_rvalid_o), 32'h1);
      chk(is_wr ? "bresp" : "rresp", 32'(is_wr ? inport_bresp_o : inport_rresp_o),
          32'(eresp));
      if (!is_wr) chk("rdata", inport_rdata_o, erdata);
      step();
      outport_ack_i = 1'b0;
    end
    inport_bready_i = 1'b0; inport_rready_i = 1'b0;
    chk("valid_drop", 32'({inport_bvalid_o, inport_rvalid_o}), 32'h0);
  endtask

  initial begin
    bit          r_wr;
    logic [3:0]  r_strb;
    int          r_ack, grants, last;
    bit          exp_wr;

    // Reset values
    #1;
    chk("rst_flags", 32'({inport_bvalid_o, inport_rvalid_o, outport_wr_o, outport_rd_o,
                          inport_awready_o, inport_wready_o, inport_arready_o}), 32'h0);
    chk("rst_addr", outport_addr_o, 32'h0);
    chk("rst_rdata", inport_rdata_o, 32'h0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("idle_ready", 32'({inport_awready_o, inport_arready_o}), 32'h0);

    // Conflicting masters: grants alternate starting with write, every 3 cycles
    inport_awvalid_i = 1'b1; inport_wvalid_i = 1'b1; inport_arvalid_i = 1'b1;
    inport_awaddr_i = 32'h1000_0000; inport_araddr_i = 32'h2000_0000;
    inport_wdata_i = 32'h1234_5678; inport_wstrb_i = 4'h3;
    inport_bready_i = 1'b1; inport_rready_i = 1'b1;
    outport_error_i = 1'b0;
    exp_wr = 1'b1; grants = 0; last = -1;
    for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
      outport_ack_i = (outport_wr_o != 4'h0) || outport_rd_o;
      #1;
      if (inport_awready_o || inport_arready_o) begin
        chk("arb_dir", 32'({inport_awready_o, inport_wready_o, inport_arready_o}),
            exp_wr ? 32'h6 : 32'h1);
        if (last >= 0) chk("arb_gap", 32'(cyc - last), 32'd3);
        last = cyc; grants++; exp_wr = !exp_wr;
      end
      @(posedge clk_i);
      #1;
    end
    chk("arb_grants", 32'(grants), 32'd8);
    inport_awvalid_i = 1'b0; inport_wvalid_i = 1'b0; inport_arvalid_i = 1'b0;
    for (int d = 0; d < 4; d++) begin
      outport_ack_i = (outport_wr_o != 4'h0) || outport_rd_o;
      step();
    end
    outport_ack_i = 1'b0; inport_bready_i = 1'b0; inport_rready_i = 1'b0;
    chk("arb_drained", 32'({inport_bvalid_o, inport_rvalid_o, outport_rd_o}), 32'h0);

    // Directed cases
    txn(1'b1, 32'h4000_0007, 32'hA5A5_1234, 4'hF, 3, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h4000_0010, 32'h0, 4'h0, 1, 1'b0, 32'hDEAD_BEEF, 5);
    txn(1'b1, 32'h4000_0008, 32'h0BAD_F00D, 4'h0, 2, 1'b0, 32'h0, 1);
    txn(1'b1, 32'h4000_000C, 32'h5555_AAAA, 4'h6, 2, 1'b1, 32'h0, 0);
    txn(1'b0, 32'h4000_0014, 32'h0, 4'h0, TO + 1, 1'b0, 32'hCAFE_F00D, 2);
    txn(1'b1, 32'h4000_0018, 32'h1111_2222, 4'h1, 0, 1'b0, 32'h0, 1);
    txn(1'b0, 32'h4000_001C, 32'h0, 4'h0, TO, 1'b0, 32'h0123_4567, 0);
    txn(1'b0, 32'h4000_0020, 32'h0, 4'h0, 1, 1'b1, 32'h89AB_CDEF, 1);

    // Randomized transactions
    for (int n = 0; n < 30; n++) begin
      r_wr   = 1'($urandom);
      r_strb = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      r_ack  = int'($urandom_range(0, TO + 2));
      txn(r_wr, $urandom, $urandom, r_strb, r_ack, 1'($urandom), $urandom,
          int'($urandom_range(0, 3)));
    end

    // Asynchronous reset during a read wait
    inport_arvalid_i = 1'b1; inport_araddr_i = 32'h4000_0030;
    #1 chk("rst_case_arready", 32'(inport_arready_o), 32'h1);
    step();
    inport_arvalid_i = 1'b0;
    step(); step();
    chk("pre_rst_rd", 32'(outport_rd_o), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async_req", 32'({outport_rd_o, outport_wr_o}), 32'h0);
    chk("rst_async_valid", 32'({inport_bvalid_o, inport_rvalid_o}), 32'h0);
    chk("rst_async_addr", outport_addr_o, 32'h0);
    step();
    rst_i = 1'b0;
    txn(1'b0, 32'h4000_0034, 32'h0, 4'h0, 2, 1'b0, 32'h7777_8888, 0);
    txn(1'b1, 32'h4000_0038, 32'h9999_0000, 4'hC, 1, 1'b0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
